// File: rtl/maze_pkg.sv
// maze_pkg
//   Definitions shared by the maze-solver blocks:
//     DIR_N/E/S/W     two-bit move direction codes
//     MAZE_MAX_DEPTH  default usable depth of the direction stack
//     bt_state_t      state encoding of the backtrack controller
//     inv_dir()       opposite direction (flips the N/S and E/W axis bit)
package maze_pkg;

   localparam logic [1:0] DIR_N = 2'b00;
   localparam logic [1:0] DIR_E = 2'b01;
   localparam logic [1:0] DIR_S = 2'b10;
   localparam logic [1:0] DIR_W = 2'b11;

   localparam int MAZE_MAX_DEPTH = 49;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PUSH = 3'd1,
      CPOP = 3'd2,
      GAP  = 3'd3,
      POP  = 3'd4,
      WAIT = 3'd5,
      EMIT = 3'd6,
      DONE = 3'd7
   } bt_state_t;

   function automatic logic [1:0] inv_dir(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/backtrack_ctrl.sv
// backtrack_ctrl
//   Records the forward path of the robot on an external direction stack and,
//   on request, unwinds the whole path by issuing reverse-move commands.
//
//   Optional feature (macro BACKTRACK_CANCEL_EN): a move that exactly undoes
//   the last recorded move pops the stack instead of pushing.
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     move_valid/move_dir       forward move offer (00 N, 01 E, 10 S, 11 W)
//     move_ready                move accepted this cycle
//     retrace_start             request to unwind the whole path
//     cmd_valid/cmd_dir         reverse-move command to the motor sequencer
//     cmd_ready                 motor sequencer accepts the command
//     retrace_done              one-cycle pulse when unwinding completes
//     stk_en/stk_push/stk_pop/
//     stk_push_val/stk_pop_val  direction stack interface
//     depth, full, empty, busy  path depth and status
module backtrack_ctrl
   import maze_pkg::*;
#(
   parameter int MAX_DEPTH = MAZE_MAX_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move_valid,
   input  logic [1:0] move_dir,
   output logic       move_ready,
   input  logic       retrace_start,
   output logic       cmd_valid,
   output logic [1:0] cmd_dir,
   input  logic       cmd_ready,
   output logic       retrace_done,
   output logic       stk_en,
   output logic       stk_push,
   output logic       stk_pop,
   output logic [1:0] stk_push_val,
   input  logic [1:0] stk_pop_val,
   output logic [5:0] depth,
   output logic       full,
   output logic       empty,
   output logic       busy
);

   localparam logic [5:0] DEPTH_MAX = 6'(MAX_DEPTH);

   bt_state_t  state, state_nxt;
   logic       accept;

`ifdef BACKTRACK_CANCEL_EN
   // Shadow of the stack top, used only to recognise an undoing move.
   logic       top_valid;
   logic [1:0] top_dir;
   logic       is_cancel;

   assign is_cancel = top_valid && (depth != '0) && (move_dir == inv_dir(top_dir));
`endif

   assign stk_en       = 1'b1;
   assign stk_push     = (state == PUSH);
`ifdef BACKTRACK_CANCEL_EN
   assign stk_pop      = (state == POP) || (state == CPOP);
`else
   assign stk_pop      = (state == POP);
`endif
   assign cmd_valid    = (state == EMIT);
   assign retrace_done = (state == DONE);
   assign full         = (depth == DEPTH_MAX);
   assign empty        = (depth == '0);
   assign busy         = (state != IDLE);
   assign accept       = move_valid && move_ready;

   always_comb begin
      state_nxt  = state;
      move_ready = 1'b0;
      case (state)
         IDLE: begin
            if (retrace_start) begin
               state_nxt = (depth == '0) ? DONE : POP;
            end else begin
`ifdef BACKTRACK_CANCEL_EN
               // An undoing move frees a slot, so it is taken even when full.
               move_ready = !full || is_cancel;
               if (accept)
                  state_nxt = is_cancel ? CPOP : PUSH;
`else
               move_ready = !full;
               if (accept)
                  state_nxt = PUSH;
`endif
            end
         end
         PUSH:    state_nxt = GAP;
`ifdef BACKTRACK_CANCEL_EN
         CPOP:    state_nxt = GAP;
`endif
         GAP:     state_nxt = IDLE;
         POP:     state_nxt = WAIT;
         WAIT:    state_nxt = EMIT;
         EMIT: begin
            if (cmd_ready)
               state_nxt = (depth == '0) ? DONE : POP;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         depth        <= '0;
         stk_push_val <= '0;
         cmd_dir      <= '0;
`ifdef BACKTRACK_CANCEL_EN
         top_valid    <= 1'b0;
         top_dir      <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (state == IDLE && !retrace_start && accept)
            stk_push_val <= move_dir;
         case (state)
            PUSH: begin
               if (depth != DEPTH_MAX)
                  depth <= depth + 6'd1;
`ifdef BACKTRACK_CANCEL_EN
               top_dir   <= stk_push_val;
               top_valid <= 1'b1;
`endif
            end
`ifdef BACKTRACK_CANCEL_EN
            CPOP: begin
               if (depth != '0)
                  depth <= depth - 6'd1;
               top_valid <= 1'b0;
            end
`endif
            POP: begin
               if (depth != '0)
                  depth <= depth - 6'd1;
`ifdef BACKTRACK_CANCEL_EN
               top_valid <= 1'b0;
`endif
            end
            WAIT: cmd_dir <= inv_dir(stk_pop_val);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// tb_backtrack_ctrl
//   Directed bench for backtrack_ctrl with a behavioural direction stack
//   (registered pop value, shares rst). Covers push/retrace ordering, command
//   stall, full depth, empty retrace, reset during EMIT and, when
//   BACKTRACK_CANCEL_EN is defined, cancelling moves.
module tb_backtrack_ctrl;
   import maze_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       move_valid = 1'b0;
   logic [1:0] move_dir = '0;
   logic       move_ready;
   logic       retrace_start = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic       cmd_ready = 1'b0;
   logic       retrace_done;
   logic       stk_en, stk_push, stk_pop;
   logic [1:0] stk_push_val;
   logic [1:0] stk_pop_val;
   logic [5:0] depth;
   logic       full, empty, busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   backtrack_ctrl #(.MAX_DEPTH(49)) dut (
      .clk(clk), .rst(rst),
      .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
      .retrace_start(retrace_start),
      .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
      .retrace_done(retrace_done),
      .stk_en(stk_en), .stk_push(stk_push), .stk_pop(stk_pop),
      .stk_push_val(stk_push_val), .stk_pop_val(stk_pop_val),
      .depth(depth), .full(full), .empty(empty), .busy(busy)
   );

   // Behavioural stack beside the controller.
   logic [1:0] mem [0:63];
   int         sp;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp          <= 0;
         stk_pop_val <= '0;
      end else if (stk_push && sp < 64) begin
         mem[sp] <= stk_push_val;
         sp      <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_pop_val <= mem[sp-1];
         sp          <= sp - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Waits (bounded) at negedges for cmd_valid (which=0) or retrace_done (which=1).
   task automatic wait_for(input string name, input int which);
      logic s;
      for (int i = 0; i < 12; i++) begin
         s = (which == 0) ? cmd_valid : retrace_done;
         if (s) break;
         @(negedge clk);
      end
      s = (which == 0) ? cmd_valid : retrace_done;
      check({name, " timeout"}, 32'(s), 1);
   endtask

   task automatic push_move(input logic [1:0] d, input string tag);
      @(negedge clk);
      move_valid = 1'b1;
      move_dir   = d;
      check({tag, " move_ready"}, 32'(move_ready), 1);
      @(negedge clk);
      move_valid = 1'b0;
      check({tag, " stk_push hi"}, 32'(stk_push), 1);
      @(negedge clk);
      check({tag, " stk_push lo"}, 32'(stk_push), 0);
      @(negedge clk);
   endtask

`ifdef BACKTRACK_CANCEL_EN
   task automatic cancel_move(input logic [1:0] d, input int exp_depth, input string tag);
      @(negedge clk);
      move_valid = 1'b1;
      move_dir   = d;
      check({tag, " move_ready"}, 32'(move_ready), 1);
      @(negedge clk);
      move_valid = 1'b0;
      check({tag, " stk_pop hi"}, 32'(stk_pop), 1);
      check({tag, " no push"}, 32'(stk_push), 0);
      @(negedge clk);
      check({tag, " stk_pop lo"}, 32'(stk_pop), 0);
      check({tag, " no cmd"}, 32'(cmd_valid), 0);
      @(negedge clk);
      check({tag, " depth"}, 32'(depth), 32'(exp_depth));
      check({tag, " idle"}, 32'(busy), 0);
   endtask
`endif

   typedef struct {
      logic [1:0] dir;
      int         exp_depth;
      logic       exp_full;
      logic       exp_empty;
   } push_vec_t;

   push_vec_t vecs [3];
   logic [1:0] exp_cmd [3];
   logic [1:0] held;

   initial begin
      vecs[0] = '{DIR_N, 1, 1'b0, 1'b0};
      vecs[1] = '{DIR_E, 2, 1'b0, 1'b0};
      vecs[2] = '{DIR_E, 3, 1'b0, 1'b0};
      exp_cmd[0] = DIR_W;
      exp_cmd[1] = DIR_W;
      exp_cmd[2] = DIR_S;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst depth", 32'(depth), 0);
      check("rst empty", 32'(empty), 1);
      check("rst full", 32'(full), 0);
      check("rst busy", 32'(busy), 0);
      check("rst stk_push", 32'(stk_push), 0);
      check("rst stk_pop", 32'(stk_pop), 0);
      check("rst cmd_valid", 32'(cmd_valid), 0);
      check("rst retrace_done", 32'(retrace_done), 0);
      check("rst stk_push_val", 32'(stk_push_val), 0);
      check("rst cmd_dir", 32'(cmd_dir), 0);
      rst = 1'b0;
      @(negedge clk);
      check("stk_en", 32'(stk_en), 1);

      // Push N,E,E
      for (int i = 0; i < 3; i++) begin
         push_move(vecs[i].dir, $sformatf("push%0d", i));
         check($sformatf("push%0d depth", i), 32'(depth), 32'(vecs[i].exp_depth));
         check($sformatf("push%0d full", i), 32'(full), 32'(vecs[i].exp_full));
         check($sformatf("push%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      end

      // Retrace N,E,E -> W,W,S
      cmd_ready     = 1'b1;
      retrace_start = 1'b1;
      @(negedge clk);
      retrace_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_for($sformatf("cmd%0d", k), 0);
         check($sformatf("cmd%0d dir", k), 32'(cmd_dir), 32'(exp_cmd[k]));
         @(negedge clk);
      end
      wait_for("retrace_done", 1);
      check("retrace depth", 32'(depth), 0);
      check("retrace empty", 32'(empty), 1);
      @(negedge clk);
      check("done pulse 1 cycle", 32'(retrace_done), 0);

      // Stall in EMIT: push N,E, retrace with cmd_ready low
      push_move(DIR_N, "stall pushN");
      push_move(DIR_E, "stall pushE");
      cmd_ready     = 1'b0;
      retrace_start = 1'b1;
      @(negedge clk);
      retrace_start = 1'b0;
      wait_for("stall cmd", 0);
      check("stall cmd dir", 32'(cmd_dir), 32'(DIR_W));
      held = cmd_dir;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall cmd_valid", 32'(cmd_valid), 1);
         check("stall cmd_dir", 32'(cmd_dir), 32'(held));
         check("stall no pop", 32'(stk_pop), 0);
      end
      check("stall depth", 32'(depth), 1);
      cmd_ready = 1'b1;
      @(negedge clk);
      wait_for("stall cmd2", 0);
      check("stall cmd2 dir", 32'(cmd_dir), 32'(DIR_S));
      @(negedge clk);
      wait_for("stall done", 1);
      check("stall final depth", 32'(depth), 0);

      // Retrace with empty path
      @(negedge clk);
      retrace_start = 1'b1;
      @(negedge clk);
      retrace_start = 1'b0;
      check("empty retrace done", 32'(retrace_done), 1);
      @(negedge clk);
      check("empty retrace idle", 32'(busy), 0);

      // Reset while EMIT is waiting
      push_move(DIR_E, "rst pushE");
      cmd_ready     = 1'b0;
      retrace_start = 1'b1;
      @(negedge clk);
      retrace_start = 1'b0;
      wait_for("rst emit", 0);
      rst = 1'b1;
      #1;
      check("rst emit cmd_valid", 32'(cmd_valid), 0);
      check("rst emit depth", 32'(depth), 0);
      check("rst emit busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;

`ifdef BACKTRACK_CANCEL_EN
      // E then W cancels; then E,E,W leaves depth 1
      push_move(DIR_E, "cxl E");
      cancel_move(DIR_W, 0, "cxl W");
      push_move(DIR_E, "cxl E2");
      push_move(DIR_E, "cxl E3");
      cancel_move(DIR_W, 1, "cxl W2");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif

      // Fill to 49
      for (int i = 0; i < 49; i++)
         push_move(DIR_N, "fill");
      check("fill depth", 32'(depth), 49);
      check("fill full", 32'(full), 1);
      @(negedge clk);
      move_valid = 1'b1;
      move_dir   = DIR_N;
      #1;
      check("full move_ready", 32'(move_ready), 0);
      repeat (3) @(negedge clk);
      check("full depth held", 32'(depth), 49);
      check("full no push", 32'(stk_push), 0);
      check("full idle", 32'(busy), 0);
`ifdef BACKTRACK_CANCEL_EN
      move_dir = DIR_S;
      #1;
      check("full cancel ready", 32'(move_ready), 1);
`endif
      move_valid = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/backtrack_ctrl.md
BACKTRACK_CTRL -- requirements
Module: backtrack_ctrl

Interface
REQ-001 SHALL have parameter MAX_DEPTH, default 49, meaning the usable entries of the attached direction stack.
REQ-002 SHALL have port clk, input, 1 bit, the clock.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port move_valid, input, 1 bit, meaning a forward move is offered.
REQ-005 SHALL have port move_dir, input, 2 bits, the move direction (00 N, 01 E, 10 S, 11 W).
REQ-006 SHALL have port move_ready, output, 1 bit, meaning the move is accepted this cycle.
REQ-007 SHALL have port retrace_start, input, 1 bit, a request to unwind the whole path.
REQ-008 SHALL have port cmd_valid, output, 1 bit, and port cmd_dir, output, 2 bits, carrying a reverse-move command to the motor sequencer.
REQ-009 SHALL have port cmd_ready, input, 1 bit, meaning the motor sequencer accepts the command.
REQ-010 SHALL have port retrace_done, output, 1 bit, a one-cycle pulse when unwinding completes.
REQ-011 SHALL have ports stk_en, stk_push, stk_pop, stk_push_val (2 bits), all outputs, and stk_pop_val (2 bits), input, forming the stack interface.
REQ-012 SHALL have port depth, output, 6 bits, and ports full, empty, busy, all outputs, 1 bit each.

Function
REQ-013 SHALL drive stk_en constant 1 out of reset.
REQ-014 SHALL use the FSM states IDLE, PUSH, CPOP, GAP, POP, WAIT, EMIT and DONE.
REQ-015 SHALL assert move_ready only in IDLE while full=0 and retrace_start=0.
REQ-016 SHALL give retrace_start priority over move_valid in IDLE.
REQ-017 SHALL, on an accepted move, register move_dir into stk_push_val and go to PUSH.
REQ-018 SHALL, in PUSH, assert stk_push for exactly one cycle, increment depth, set top_dir=move_dir and top_valid=1, then go to GAP.
REQ-019 SHALL, in GAP, hold stk_push=0 and stk_pop=0 for one cycle (re-arming the stack edge detectors), then return to IDLE.
REQ-020 SHALL, in IDLE with retrace_start=1, go to POP if depth>0 and to DONE if depth=0.
REQ-021 SHALL, in POP, assert stk_pop for one cycle, decrement depth, clear top_valid, then go to WAIT.
REQ-022 SHALL, in WAIT, deassert stk_pop and latch cmd_dir = stk_pop_val XOR 2'b10 (the inverse direction), then go to EMIT.
REQ-023 SHALL, in EMIT, hold cmd_valid=1 with stable cmd_dir until cmd_ready=1, then go to POP if depth>0 and to DONE if depth=0.
REQ-024 SHALL, in DONE, pulse retrace_done for one cycle and then return to IDLE.
REQ-025 SHALL set full = (depth==MAX_DEPTH), empty = (depth==0), and busy = (state!=IDLE).
REQ-026 SHALL never let depth exceed MAX_DEPTH nor fall below 0.
REQ-027 SHALL ignore retrace_start and move_valid outside IDLE, and SHALL have no abort path other than rst.

Reset
REQ-028 SHALL, on rst, immediately force state=IDLE, depth=0, top_valid=0, and 0 on stk_push, stk_pop, stk_push_val, cmd_valid, cmd_dir and retrace_done.
REQ-029 SHALL, on rst mid-retrace, drop the pending command without a handshake; the stack shares rst and empties in the same event.

Configuration
REQ-030 SHALL, with BACKTRACK_CANCEL_EN defined, treat an accepted move with top_valid=1, depth>0 and move_dir==top_dir XOR 2'b10 as a cancel: go to CPOP, assert stk_pop for one cycle, decrement depth, clear top_valid, discard the popped value, then go to GAP.
REQ-031 SHALL, with BACKTRACK_CANCEL_EN defined, keep move_ready=1 when full=1 if the offered move is a cancel.
REQ-032 SHALL, without BACKTRACK_CANCEL_EN, contain no CPOP logic and push every accepted move.

Structure
REQ-033 SHALL take the direction constants, the inverse-direction function, MAX_DEPTH default and FSM state encoding from shared package maze_pkg.
REQ-034 SHALL contain no sub-module; the stack is instantiated beside this block by the parent.

Verification
REQ-035 SHALL cover: push N,E,E -> depth=3, each stk_push high exactly 1 cycle followed by a low cycle.
REQ-036 SHALL cover: retrace from N,E,E with cmd_ready=1 -> cmd_dir W,W,S in that order, then retrace_done, depth=0, empty=1.
REQ-037 SHALL cover: cmd_ready held 0 for 5 cycles in EMIT -> cmd_valid and cmd_dir stable throughout, no further stk_pop.
REQ-038 SHALL cover: 49 pushes -> full=1, move_ready=0; a 50th non-cancel move is not accepted and depth stays 49.
REQ-039 SHALL cover: with BACKTRACK_CANCEL_EN, E then W -> depth returns to 0, no cmd_valid; a following E, E, W -> depth=1.
REQ-040 SHALL cover: retrace_start with depth=0 -> retrace_done within 2 cycles; rst asserted in EMIT -> cmd_valid=0 immediately and depth=0.
